// File: rtl/hex_uart_tx.sv
// Sends each accepted DATA_W-bit word as uppercase ASCII hex plus a line terminator over an 8N1 UART.
// Build option HEX_UART_CRLF_EN selects a CR LF terminator; otherwise a single space is sent.
module hex_uart_tx #(
  parameter int CLK_FREQ = 48000000,
  parameter int BAUD     = 1200,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_stb,
  output logic              in_rdy,
  output logic              tx_out,
  output logic              busy,
  output logic [7:0]        ovf_cnt
);

  localparam int SYM_CNT = CLK_FREQ / BAUD;
  localparam int DIGITS  = DATA_W / 4;
`ifdef HEX_UART_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 1;
`endif
  localparam int NCHR = DIGITS + TERM_LEN;
  localparam int TW   = $clog2(SYM_CNT + 1);
  localparam int CW   = $clog2(NCHR + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [2:0]        bit_idx, bit_n;
  logic [CW-1:0]     chr_idx, chr_n;
  logic [DATA_W-1:0] word;
  logic              accept, sym_end, tx_n;
  logic [7:0]        chr_byte;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Character idx of the frame: hex digits MSB nibble first, then the terminator.
  function automatic logic [7:0] char_at(input logic [DATA_W-1:0] w, input logic [CW-1:0] idx);
    logic [7:0] c;
`ifdef HEX_UART_CRLF_EN
    c = (idx == CW'(DIGITS)) ? 8'h0D : 8'h0A;
`else
    c = 8'h20;
`endif
    for (int i = 0; i < DIGITS; i++)
      if (idx == CW'(i)) c = nib_to_ascii(w[DATA_W-1-4*i -: 4]);
    return c;
  endfunction

  assign accept  = in_stb & in_rdy;
  assign sym_end = (timer == TW'(SYM_CNT - 1));

  // Next-state: timer restarts at 0 whenever the state or the bit changes.
  always_comb begin
    state_n  = state;
    timer_n  = timer + 1'b1;
    bit_n    = bit_idx;
    chr_n    = chr_idx;
    tx_n     = 1'b1;
    chr_byte = 8'hFF;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (accept) begin
          state_n = START;
          chr_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (sym_end) begin
          timer_n = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (sym_end) begin
          timer_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (sym_end) begin
          timer_n = '0;
          if (chr_idx == CW'(NCHR - 1)) begin
            state_n = IDLE;
          end else begin
            chr_n   = chr_idx + 1'b1;
            state_n = START;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA: begin
        chr_byte = char_at(word, chr_n);
        tx_n     = chr_byte[bit_n];
      end
      default: tx_n = 1'b1;
    endcase
  end

  // Registered control and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      chr_idx <= '0;
      tx_out  <= 1'b1;
      in_rdy  <= 1'b1;
      busy    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_n;
      chr_idx <= chr_n;
      tx_out  <= tx_n;
      in_rdy  <= (state_n == IDLE);
      busy    <= (state_n != IDLE);
      if (in_stb && !in_rdy && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  // Word is data only; it is meaningful solely after an accept.
  always_ff @(posedge clk) begin
    if (accept) word <= in_dat;
  end

endmodule

// File: tb/tb_hex_uart_tx.sv
// Bench for hex_uart_tx: a mid-bit UART monitor decodes tx_out and frames are checked against a hex-text model.
module tb_hex_uart_tx;

  localparam int SYM = 16;
`ifdef HEX_UART_CRLF_EN
  localparam int NCHR = 8;
`else
  localparam int NCHR = 7;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_dat;
  logic        in_stb;
  logic        in_rdy, tx_out, busy;
  logic [7:0]  ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_exp = 0;
  bit pulse_mask [0:4999];

  hex_uart_tx #(.CLK_FREQ(16), .BAUD(1), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_stb(in_stb),
    .in_rdy(in_rdy), .tx_out(tx_out), .busy(busy), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // UART monitor: detect start edge, sample each bit at its middle.
  bit          mon_busy = 1'b0;
  int          mon_cnt  = 0;
  int          mon_j;
  logic [9:0]  mon_sh;
  int          mon_err  = 0;
  logic [7:0]  rx_q[$];

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx_out === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % SYM == SYM / 2) begin
        mon_j = mon_cnt / SYM;
        mon_sh[mon_j] = tx_out;
        if (mon_j == 9) begin
          if (mon_sh[0] !== 1'b0 || mon_sh[9] !== 1'b1) mon_err++;
          rx_q.push_back(mon_sh[8:1]);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mask;
    for (int i = 0; i < 5000; i++) pulse_mask[i] = 1'b0;
  endtask

  // Accepts w (in_rdy must be 1), applies pulse_mask, then checks timing, bytes and ovf_cnt.
  task automatic run_frame(input logic [23:0] w);
    logic [7:0] exp_q[$];
    int n, len, v;
    for (int i = 0; i < 6; i++) begin
      v = int'((w >> (20 - 4 * i)) & 24'hF);
      exp_q.push_back(8'(v < 10 ? 48 + v : 55 + v));
    end
`ifdef HEX_UART_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
    len = exp_q.size() * 10 * SYM + 1;
    rx_q.delete();
    mon_err = 0;
    check("rdy_before_accept", 32'(in_rdy), 32'd1);
    in_stb = 1'b1;
    in_dat = w;
    tick;
    in_stb = 1'b0;
    in_dat = 24'($urandom);
    check("start_latency", 32'(tx_out), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    check("rdy_in_frame", 32'(in_rdy), 32'd0);
    n = 1;
    while (!in_rdy && n < 4999) begin
      if (pulse_mask[n]) begin
        in_stb = 1'b1;
        if (ovf_exp < 255) ovf_exp++;
      end
      tick;
      in_stb = 1'b0;
      n++;
    end
    check("frame_len", 32'(n), 32'(len));
    check("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    check("framing", 32'(mon_err), 32'd0);
    check("ovf_cnt", 32'(ovf_cnt), 32'(ovf_exp));
    check("tx_idle_after", 32'(tx_out), 32'd1);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    in_stb = 1'b0;
    in_dat = '0;
    clear_mask();
    repeat (3) tick;
    check("rst_tx", 32'(tx_out), 32'd1);
    check("rst_rdy", 32'(in_rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    rst = 1'b0;

    bad = 0;
    repeat (100) begin
      tick;
      if (tx_out !== 1'b1 || in_rdy !== 1'b1 || ovf_cnt !== 8'd0) bad++;
    end
    check("idle_100", 32'(bad), 32'd0);

    run_frame(24'h00A3F1);
    run_frame(24'hFFFFFF);
    run_frame(24'h000000);

    // Three drops mid-frame.
    pulse_mask[100 + $urandom_range(0, 50)] = 1'b1;
    pulse_mask[400 + $urandom_range(0, 50)] = 1'b1;
    pulse_mask[800 + $urandom_range(0, 50)] = 1'b1;
    run_frame(24'($urandom));
    clear_mask();

    // Strobe on the final STOP cycle is still a drop.
    pulse_mask[NCHR * 10 * SYM] = 1'b1;
    run_frame(24'($urandom));
    clear_mask();

    // Back-to-back: accept on the first cycle in_rdy is high.
    run_frame(24'($urandom));

    // 300 drops saturate the counter.
    for (int i = 0; i < 300; i++) pulse_mask[1 + 2 * i] = 1'b1;
    run_frame(24'($urandom));
    clear_mask();

    // Reset in the 3rd data bit of char 2.
    in_stb = 1'b1;
    in_dat = 24'($urandom);
    tick;
    in_stb = 1'b0;
    repeat (374) tick;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ovf_exp = 0;
    check("midrst_tx", 32'(tx_out), 32'd1);
    check("midrst_rdy", 32'(in_rdy), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovf", 32'(ovf_cnt), 32'd0);
    tick;
    run_frame(24'($urandom));

    repeat (2) begin
      repeat ($urandom_range(0, 20)) tick;
      run_frame(24'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
